// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the BRAM port-B arbiter: default widths and the
// read-return tag encoding.
package dmem_port_arbiter_pkg;

    localparam int DMEM_ADDR_WIDTH  = 9;
    localparam int DMEM_DATA_WIDTH  = 16;
    localparam int STARVE_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_P0   = 2'd1,
        TAG_P1   = 2'd2
    } rd_tag_e;

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles requester 1 was denied; raises
// force1 once the count reaches MAX_WAIT so requester 1 wins next.
module arb_starve_ctr
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req1,
    input  logic                        gnt1,
    output logic                        force1,
    output logic [STARVE_CNT_WIDTH-1:0] wait_cnt
);

    localparam logic [STARVE_CNT_WIDTH-1:0] MAX_CNT = STARVE_CNT_WIDTH'(MAX_WAIT);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (req1 && !gnt1) begin
            if (wait_cnt < MAX_CNT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    assign force1 = (wait_cnt >= MAX_CNT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for BRAM port B: fixed priority to requester 0 with a
// starvation guard for requester 1, and 1-cycle read-data return routing.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0,
    input  logic                        we0,
    input  logic [ADDR_WIDTH-1:0]       addr0,
    input  logic [DATA_WIDTH-1:0]       wdata0,
    output logic                        gnt0,
    output logic                        rvalid0,
    output logic [DATA_WIDTH-1:0]       rdata0,
    input  logic                        req1,
    input  logic                        we1,
    input  logic [ADDR_WIDTH-1:0]       addr1,
    input  logic [DATA_WIDTH-1:0]       wdata1,
    output logic                        gnt1,
    output logic                        rvalid1,
    output logic [DATA_WIDTH-1:0]       rdata1,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_din,
    input  logic [DATA_WIDTH-1:0]       mem_dout,
    output logic [STARVE_CNT_WIDTH-1:0] starve_cnt
);

    logic                        force1;
    logic [STARVE_CNT_WIDTH-1:0] wait_cnt;
    rd_tag_e                     rd_tag_d;
    rd_tag_e                     rd_tag_q;
    logic [DATA_WIDTH-1:0]       rdata0_q;
    logic [DATA_WIDTH-1:0]       rdata1_q;

    arb_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req1     (req1),
        .gnt1     (gnt1),
        .force1   (force1),
        .wait_cnt (wait_cnt)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = addr0;
        mem_din  = wdata0;
        rd_tag_d = TAG_NONE;

        // Grants are suppressed while reset is held so the BRAM sees no access.
        if (rst_n) begin
            gnt1 = req1 & (~req0 | force1);
            gnt0 = req0 & ~gnt1;
        end

        if (gnt1) begin
            mem_en   = 1'b1;
            mem_we   = we1;
            mem_addr = addr1;
            mem_din  = wdata1;
            if (!we1) rd_tag_d = TAG_P1;
        end else if (gnt0) begin
            mem_en   = 1'b1;
            mem_we   = we0;
            mem_addr = addr0;
            mem_din  = wdata0;
            if (!we0) rd_tag_d = TAG_P0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_tag_q <= TAG_NONE;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rd_tag_q <= rd_tag_d;
            if (rvalid0) rdata0_q <= mem_dout;
            if (rvalid1) rdata1_q <= mem_dout;
        end
    end

    // Read data passes straight through on the valid cycle and is held afterwards.
    assign rvalid0    = (rd_tag_q == TAG_P0);
    assign rvalid1    = (rd_tag_q == TAG_P1);
    assign rdata0     = rvalid0 ? mem_dout : rdata0_q;
    assign rdata1     = rvalid1 ? mem_dout : rdata1_q;
    assign starve_cnt = wait_cnt;

endmodule
